alu_operand_sequencer: RTL and testbench

// Upstream/downstream companion of the N-bit ALU on the Lab3 board.

---
 rtl/alu_pkg.sv | 40 ++++
 rtl/rise_detect.sv | 31 +++
 rtl/alu_operand_sequencer.sv | 155 +++++++++++++++
 tb/tb_alu_operand_sequencer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Brief    : Shared opcode, state and flag-index definitions for the ALU
//            operand sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

  // ALU opcodes; anything above ALU_OP_MAX is rejected by the sequencer
  localparam logic [3:0] ALU_ADD    = 4'd0;
  localparam logic [3:0] ALU_SUB    = 4'd1;
  localparam logic [3:0] ALU_AND    = 4'd2;
  localparam logic [3:0] ALU_OR     = 4'd3;
  localparam logic [3:0] ALU_NOT    = 4'd4;
  localparam logic [3:0] ALU_XOR    = 4'd5;
  localparam logic [3:0] ALU_OP_MAX = ALU_XOR;

  // Bit positions inside the captured flag word {N,Z,C,V}
  localparam int FLAG_V = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_Z = 2;
  localparam int FLAG_N = 3;

  // Sequencer states; encoding is exported on the LED port
  typedef enum logic [2:0] {
    LOAD_A  = 3'd0,
    LOAD_B  = 3'd1,
    LOAD_OP = 3'd2,
    EXEC    = 3'd3,
    HOLD    = 3'd4
  } state_t;

  // True when the opcode is one the ALU implements
  function automatic logic op_is_legal(input logic [3:0] op);
    return (op <= ALU_OP_MAX);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rise_detect.sv
`default_nettype none
// ============================================================================
// Module   : rise_detect
// Brief    : Single-flop rising-edge detector with a configurable reset value.
//            Resetting to 1 suppresses a pulse for a level held through reset.
// Revision : 1.0 - initial release
// ============================================================================
module rise_detect #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_level,
  output logic o_pulse
);

  logic r_level_q;

  // Remember the previous level of the input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_level_q <= RST_VAL;
    end else begin
      r_level_q <= i_level;
    end
  end

  assign o_pulse = i_level & ~r_level_q;

endmodule
`default_nettype wire

// File: rtl/alu_operand_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_operand_sequencer
// Brief    : Loads A, B and opcode/carry-in from the switch bus over successive
//            enter presses, runs one ALU execute cycle, captures result and
//            flags, and supports chaining the result back in as the next A.
//            NBits must be at least 5 (cin lives in data_in[4]).
// Revision : 1.0 - initial release
// ============================================================================
module alu_operand_sequencer
  import alu_pkg::*;
#(
  parameter int NBits = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NBits-1:0] data_in,
  input  logic             enter,
  input  logic             clear,
  output logic [NBits-1:0] alu_a,
  output logic [NBits-1:0] alu_b,
  output logic [3:0]       alu_sel,
  output logic             alu_cin,
  input  logic [NBits-1:0] alu_result,
  input  logic             alu_zero,
  input  logic             alu_negative,
  input  logic             alu_carry,
  input  logic             alu_overflow,
  output logic [NBits-1:0] res_q,
  output logic [3:0]       flags_q,
  output logic             res_valid,
  output logic             op_err,
  output logic [7:0]       op_count,
  output logic [2:0]       state_o
);

  logic             w_enter_pulse;
  logic [3:0]       w_flags;

  state_t           r_state;
  logic [NBits-1:0] r_alu_a;
  logic [NBits-1:0] r_alu_b;
  logic [3:0]       r_alu_sel;
  logic             r_alu_cin;
  logic [NBits-1:0] r_res_q;
  logic [3:0]       r_flags_q;
  logic             r_res_valid;
  logic             r_op_err;
  logic [7:0]       r_op_count;

  // Reset value 1 so a button held through reset does not count as a press
  rise_detect #(
    .RST_VAL (1'b1)
  ) u_enter_edge (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_level (enter),
    .o_pulse (w_enter_pulse)
  );

  always_comb begin
    w_flags         = 4'b0000;
    w_flags[FLAG_N] = alu_negative;
    w_flags[FLAG_Z] = alu_zero;
    w_flags[FLAG_C] = alu_carry;
    w_flags[FLAG_V] = alu_overflow;
  end

  // Operand-capture state machine with registered ALU drive and result outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= LOAD_A;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_sel   <= 4'd0;
      r_alu_cin   <= 1'b0;
      r_res_q     <= '0;
      r_flags_q   <= 4'd0;
      r_res_valid <= 1'b0;
      r_op_err    <= 1'b0;
      r_op_count  <= 8'd0;
    end else begin
      r_op_err <= 1'b0;
      if (clear) begin
        // Abort wins over any press in the same cycle; op_count survives
        r_state     <= LOAD_A;
        r_alu_a     <= '0;
        r_alu_b     <= '0;
        r_alu_sel   <= 4'd0;
        r_alu_cin   <= 1'b0;
        r_res_q     <= '0;
        r_flags_q   <= 4'd0;
        r_res_valid <= 1'b0;
      end else begin
        case (r_state)
          LOAD_A: begin
            if (w_enter_pulse) begin
              r_alu_a     <= data_in;
              r_res_valid <= 1'b0;
              r_state     <= LOAD_B;
            end
          end
          LOAD_B: begin
            if (w_enter_pulse) begin
              r_alu_b <= data_in;
              r_state <= LOAD_OP;
            end
          end
          LOAD_OP: begin
            if (w_enter_pulse) begin
              if (op_is_legal(data_in[3:0])) begin
                r_alu_sel <= data_in[3:0];
                r_alu_cin <= data_in[4];
                r_state   <= EXEC;
              end else begin
                r_op_err <= 1'b1;
              end
            end
          end
          EXEC: begin
            // Operands have been stable on the ALU for a full cycle here
            r_res_q     <= alu_result;
            r_flags_q   <= w_flags;
            r_res_valid <= 1'b1;
            r_op_count  <= r_op_count + 8'd1;
            r_state     <= HOLD;
          end
          HOLD: begin
            if (w_enter_pulse) begin
              r_alu_a     <= r_res_q;
              r_res_valid <= 1'b0;
              r_state     <= LOAD_B;
            end
          end
          default: begin
            r_state <= LOAD_A;
          end
        endcase
      end
    end
  end

  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign alu_sel   = r_alu_sel;
  assign alu_cin   = r_alu_cin;
  assign res_q     = r_res_q;
  assign flags_q   = r_flags_q;
  assign res_valid = r_res_valid;
  assign op_err    = r_op_err;
  assign op_count  = r_op_count;
  assign state_o   = r_state;

endmodule
`default_nettype wire

// File: tb/tb_alu_operand_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_operand_sequencer
// Brief    : Directed self-checking bench for alu_operand_sequencer, with a
//            behavioural 8-bit ALU closing the loop.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_operand_sequencer;

  logic       clk;
  logic       rst_n;
  logic [7:0] data_in;
  logic       enter;
  logic       clear;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [3:0] alu_sel;
  logic       alu_cin;
  logic [7:0] alu_result;
  logic       alu_zero;
  logic       alu_negative;
  logic       alu_carry;
  logic       alu_overflow;
  logic [7:0] res_q;
  logic [3:0] flags_q;
  logic       res_valid;
  logic       op_err;
  logic [7:0] op_count;
  logic [2:0] state_o;

  int checks;
  int errors;

  logic [8:0] w_sum;

  alu_operand_sequencer #(
    .NBits (8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .data_in      (data_in),
    .enter        (enter),
    .clear        (clear),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_sel      (alu_sel),
    .alu_cin      (alu_cin),
    .alu_result   (alu_result),
    .alu_zero     (alu_zero),
    .alu_negative (alu_negative),
    .alu_carry    (alu_carry),
    .alu_overflow (alu_overflow),
    .res_q        (res_q),
    .flags_q      (flags_q),
    .res_valid    (res_valid),
    .op_err       (op_err),
    .op_count     (op_count),
    .state_o      (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: SUB is a + ~b + 1 (carry = no borrow), logic ops clear C/V
  always_comb begin
    w_sum        = 9'd0;
    alu_result   = 8'd0;
    alu_carry    = 1'b0;
    alu_overflow = 1'b0;
    case (alu_sel)
      4'd0: begin
        w_sum        = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_cin};
        alu_result   = w_sum[7:0];
        alu_carry    = w_sum[8];
        alu_overflow = (alu_a[7] == alu_b[7]) && (w_sum[7] != alu_a[7]);
      end
      4'd1: begin
        w_sum        = {1'b0, alu_a} + {1'b0, ~alu_b} + 9'd1;
        alu_result   = w_sum[7:0];
        alu_carry    = w_sum[8];
        alu_overflow = (alu_a[7] != alu_b[7]) && (w_sum[7] != alu_a[7]);
      end
      4'd2:    alu_result = alu_a & alu_b;
      4'd3:    alu_result = alu_a | alu_b;
      4'd4:    alu_result = ~alu_a;
      4'd5:    alu_result = alu_a ^ alu_b;
      default: alu_result = 8'd0;
    endcase
  end

  assign alu_zero     = (alu_result == 8'd0);
  assign alu_negative = alu_result[7];

  // Global time limit so the run always ends
  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "time limit reached");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One button press: rise at a negedge, released one cycle later
  task automatic press(input logic [7:0] v);
    @(negedge clk);
    data_in = v;
    enter   = 1'b1;
    @(negedge clk);
    enter   = 1'b0;
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rst_n   = 1'b0;
    enter   = 1'b1;
    clear   = 1'b0;
    data_in = 8'h55;

    // Reset with the button held down
    repeat (2) @(negedge clk);
    chk("rst_state", 16'(state_o), 16'h0);
    chk("rst_alu_a", 16'(alu_a), 16'h0);
    chk("rst_res_valid", 16'(res_valid), 16'h0);
    chk("rst_op_count", 16'(op_count), 16'h0);
    chk("rst_flags", 16'(flags_q), 16'h0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("held_enter_no_adv", 16'(state_o), 16'h0);
    enter = 1'b0;

    // 5 + 3 ADD
    press(8'h05);
    chk("ld_a", 16'(alu_a), 16'h05);
    press(8'h03);
    press(8'h00);
    chk("exec_state", 16'(state_o), 16'h3);
    chk("exec_not_valid", 16'(res_valid), 16'h0);
    @(negedge clk);
    chk("add_res", 16'(res_q), 16'h08);
    chk("add_flags", 16'(flags_q), 16'h0);
    chk("add_valid", 16'(res_valid), 16'h1);
    chk("add_count", 16'(op_count), 16'h1);
    chk("hold_state", 16'(state_o), 16'h4);

    // Chain 0x08 XOR 0x02; data on the chaining press is ignored
    press(8'hFF);
    chk("chain_a", 16'(alu_a), 16'h08);
    chk("chain_valid", 16'(res_valid), 16'h0);
    chk("chain_state", 16'(state_o), 16'h1);
    press(8'h02);
    press(8'h05);
    @(negedge clk);
    chk("xor_res", 16'(res_q), 16'h0A);
    chk("xor_count", 16'(op_count), 16'h2);

    // Clear together with a press in LOAD_OP
    press(8'h00);
    press(8'h33);
    @(negedge clk);
    data_in = 8'h00;
    enter   = 1'b1;
    clear   = 1'b1;
    @(negedge clk);
    enter   = 1'b0;
    clear   = 1'b0;
    chk("clr_state", 16'(state_o), 16'h0);
    chk("clr_alu_a", 16'(alu_a), 16'h0);
    chk("clr_alu_b", 16'(alu_b), 16'h0);
    chk("clr_res", 16'(res_q), 16'h0);
    chk("clr_valid", 16'(res_valid), 16'h0);
    chk("clr_count", 16'(op_count), 16'h2);

    // 0x7F + 0x01 -> 0x80, N and V
    press(8'h7F);
    press(8'h01);
    press(8'h00);
    @(negedge clk);
    chk("ovf_res", 16'(res_q), 16'h80);
    chk("ovf_flags", 16'(flags_q), 16'h9);

    // 3 - 3 -> 0, Z and C (no borrow)
    do_clear();
    press(8'h03);
    press(8'h03);
    press(8'h01);
    @(negedge clk);
    chk("sub_res", 16'(res_q), 16'h00);
    chk("sub_flags", 16'(flags_q), 16'h6);
    chk("sub_count", 16'(op_count), 16'h4);

    // Illegal opcode then AND
    do_clear();
    press(8'h0C);
    press(8'h0A);
    press(8'h09);
    chk("err_pulse", 16'(op_err), 16'h1);
    chk("err_state", 16'(state_o), 16'h2);
    @(negedge clk);
    chk("err_one_cycle", 16'(op_err), 16'h0);
    press(8'h02);
    @(negedge clk);
    chk("and_res", 16'(res_q), 16'h08);
    chk("and_count", 16'(op_count), 16'h5);

    // Run op_count up to 255 by chaining ADDs
    for (int i = 0; i < 250; i++) begin
      press(8'h00);
      press(8'h01);
      press(8'h00);
      @(negedge clk);
    end
    chk("count_255", 16'(op_count), 16'hFF);
    press(8'h00);
    press(8'h01);
    press(8'h10);
    chk("cin_set", 16'(alu_cin), 16'h1);
    chk("sel_add", 16'(alu_sel), 16'h0);
    @(negedge clk);
    chk("count_wrap", 16'(op_count), 16'h00);

    // Asynchronous reset mid-sequence
    press(8'h00);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_a", 16'(alu_a), 16'h0);
    chk("midrst_state", 16'(state_o), 16'h0);
    chk("midrst_valid", 16'(res_valid), 16'h0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
